flow_ctrl: RTL and testbench

- Program-flow unit that consumes the ALU's carry/zero/sign flags.
- Holds the status register (SR) and the program counter (PC).
- Executes the flow-class opcodes: TRAP, NOP, JMP, JZ, JS, JZS, LSR and XSR.
- Sits between instruction decode, which issues ops, and fetch, which consumes the PC; ALU flag results are written in through a dedicated port.

---
 rtl/flow_ctrl_if.sv | 31 +++
 rtl/flow_ctrl.sv | 125 ++++++++++++
 tb/tb_flow_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/flow_ctrl_if.sv
// Handshake and status bundle between decode/fetch/ALU and the flow-control unit.
interface flow_ctrl_if #(
  parameter int ADDR_W = 20
);
  logic              op_valid;
  logic              op_ready;
  logic [3:0]        op_code;
  logic [ADDR_W-1:0] op_arg;
  logic              flag_we;
  logic              flag_c;
  logic              flag_z;
  logic              flag_s;
  logic [2:0]        sr;
  logic [ADDR_W-1:0] pc;
  logic              redirect;
  logic              trap;
  logic [1:0]        trap_cause;
  logic              trap_ack;

  // Driver side: decode, ALU flag writer and trap handler.
  modport master (
    output op_valid, op_code, op_arg, flag_we, flag_c, flag_z, flag_s, trap_ack,
    input  op_ready, sr, pc, redirect, trap, trap_cause
  );

  // Flow-control unit side.
  modport slave (
    input  op_valid, op_code, op_arg, flag_we, flag_c, flag_z, flag_s, trap_ack,
    output op_ready, sr, pc, redirect, trap, trap_cause
  );
endinterface

// File: rtl/flow_ctrl.sv
// Program-flow unit: owns PC and status register {S,Z,C}, executes the
// jump/trap/SR-manipulation opcodes and handles trap entry/return.
module flow_ctrl #(
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] TRAP_VEC = 20'h00010,
  parameter logic [ADDR_W-1:0] RESET_PC = 20'h00000
) (
  input logic        clk,
  input logic        rst,
  flow_ctrl_if.slave bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  localparam logic [3:0] OP_TRAP = 4'd0;
  localparam logic [3:0] OP_NOP  = 4'd1;
  localparam logic [3:0] OP_JMP  = 4'd2;
  localparam logic [3:0] OP_JZ   = 4'd3;
  localparam logic [3:0] OP_JS   = 4'd4;
  localparam logic [3:0] OP_JZS  = 4'd5;
  localparam logic [3:0] OP_LSR  = 4'd6;
  localparam logic [3:0] OP_XSR  = 4'd7;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [2:0]        sr_q, sr_d;
  logic              redirect_q, redirect_d;
  logic [1:0]        cause_q, cause_d;

  logic [2:0]        eff;
  logic [ADDR_W-1:0] pc_inc;

  // Flags forwarded from the ALU take priority over the stored SR, so a
  // conditional jump in the same cycle as a flag write sees the new flags.
  assign eff    = bus.flag_we ? {bus.flag_s, bus.flag_z, bus.flag_c} : sr_q;
  assign pc_inc = pc_q + ADDR_W'(1);

  // Next-state, PC, SR and trap bookkeeping.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    sr_d       = eff;
    redirect_d = 1'b0;
    cause_d    = cause_q;
    case (state_q)
      ST_RUN: begin
        if (bus.op_valid) begin
          case (bus.op_code)
            OP_NOP: pc_d = pc_inc;
            OP_JMP: begin
              pc_d       = bus.op_arg;
              redirect_d = 1'b1;
            end
            OP_JZ, OP_JS, OP_JZS: begin
              if ((bus.op_code == OP_JZ  && eff[1]) ||
                  (bus.op_code == OP_JS  && eff[2]) ||
                  (bus.op_code == OP_JZS && (eff[1] | eff[2]))) begin
                pc_d       = bus.op_arg;
                redirect_d = 1'b1;
              end else begin
                pc_d = pc_inc;
              end
            end
            OP_LSR: begin
              sr_d = bus.op_arg[2:0];
              pc_d = pc_inc;
            end
            OP_XSR: begin
              sr_d = eff ^ bus.op_arg[2:0];
              pc_d = pc_inc;
            end
            default: begin
              // TRAP and every illegal opcode share the trap entry path.
              epc_d      = pc_inc;
              pc_d       = TRAP_VEC;
              redirect_d = 1'b1;
              cause_d    = (bus.op_code == OP_TRAP) ? 2'd0 : 2'd1;
              state_d    = ST_TRAP;
            end
          endcase
        end
      end
      ST_TRAP: begin
        if (bus.trap_ack) begin
          pc_d       = epc_q;
          redirect_d = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and architectural registers; reset abandons any pending trap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      epc_q      <= '0;
      sr_q       <= 3'b000;
      redirect_q <= 1'b0;
      cause_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      sr_q       <= sr_d;
      redirect_q <= redirect_d;
      cause_q    <= cause_d;
    end
  end

  assign bus.op_ready   = (state_q == ST_RUN);
  assign bus.trap       = (state_q == ST_TRAP);
  assign bus.pc         = pc_q;
  assign bus.sr         = sr_q;
  assign bus.redirect   = redirect_q;
  assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_flow_ctrl.sv
// Directed bench for flow_ctrl: vector table for the RUN-state opcodes plus
// hand-written trap entry / ignore / return / reset sequences.
module tb_flow_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  flow_ctrl_if #(.ADDR_W(20)) bus ();

  flow_ctrl #(
    .ADDR_W  (20),
    .TRAP_VEC(20'h00010),
    .RESET_PC(20'h00000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [19:0] arg;
    logic        fwe;
    logic [2:0]  fl;     // {S,Z,C}
    logic        ack;
    logic [19:0] e_pc;
    logic [2:0]  e_sr;
    logic        e_red;
    logic        e_trap;
    logic [1:0]  e_cause;
    logic        e_rdy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [19:0] pc, input logic [2:0] sr,
                         input logic red, input logic trp, input logic [1:0] cause,
                         input logic rdy);
    chk({tag, ".pc"},    32'(bus.pc),         32'(pc));
    chk({tag, ".sr"},    32'(bus.sr),         32'(sr));
    chk({tag, ".red"},   32'(bus.redirect),   32'(red));
    chk({tag, ".trap"},  32'(bus.trap),       32'(trp));
    chk({tag, ".cause"}, 32'(bus.trap_cause), 32'(cause));
    chk({tag, ".rdy"},   32'(bus.op_ready),   32'(rdy));
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [19:0] arg,
                       input logic fwe, input logic [2:0] fl, input logic ack);
    bus.op_valid = v;
    bus.op_code  = op;
    bus.op_arg   = arg;
    bus.flag_we  = fwe;
    bus.flag_s   = fl[2];
    bus.flag_z   = fl[1];
    bus.flag_c   = fl[0];
    bus.trap_ack = ack;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            v  op    arg        fwe fl      ack  pc         sr      red trp cause rdy
    vq.push_back('{1, 4'd1, 20'h0,     0, 3'b000, 0, 20'h00001, 3'b000, 0, 0, 2'd0, 1}); // NOP
    vq.push_back('{1, 4'd1, 20'h0,     0, 3'b000, 0, 20'h00002, 3'b000, 0, 0, 2'd0, 1}); // NOP
    vq.push_back('{1, 4'd1, 20'h0,     0, 3'b000, 0, 20'h00003, 3'b000, 0, 0, 2'd0, 1}); // NOP
    vq.push_back('{1, 4'd3, 20'h00400, 1, 3'b010, 0, 20'h00400, 3'b010, 1, 0, 2'd0, 1}); // JZ fwd Z=1
    vq.push_back('{1, 4'd3, 20'h00800, 1, 3'b000, 0, 20'h00401, 3'b000, 0, 0, 2'd0, 1}); // JZ fwd Z=0
    vq.push_back('{1, 4'd6, 20'h00005, 1, 3'b010, 0, 20'h00402, 3'b101, 0, 0, 2'd0, 1}); // LSR beats flag_we
    vq.push_back('{1, 4'd7, 20'h00007, 0, 3'b000, 0, 20'h00403, 3'b010, 0, 0, 2'd0, 1}); // XSR
    vq.push_back('{1, 4'd5, 20'h00020, 0, 3'b000, 0, 20'h00020, 3'b010, 1, 0, 2'd0, 1}); // JZS taken
    vq.push_back('{0, 4'd1, 20'h0,     0, 3'b000, 0, 20'h00020, 3'b010, 0, 0, 2'd0, 1}); // idle holds
    vq.push_back('{1, 4'd4, 20'h00040, 0, 3'b000, 0, 20'h00021, 3'b010, 0, 0, 2'd0, 1}); // JS not taken
    vq.push_back('{0, 4'd0, 20'h0,     1, 3'b100, 0, 20'h00021, 3'b100, 0, 0, 2'd0, 1}); // flag write only
    vq.push_back('{1, 4'd4, 20'h00030, 0, 3'b000, 0, 20'h00030, 3'b100, 1, 0, 2'd0, 1}); // JS taken
    vq.push_back('{1, 4'd2, 20'hFFFFF, 0, 3'b000, 0, 20'hFFFFF, 3'b100, 1, 0, 2'd0, 1}); // JMP top
    vq.push_back('{1, 4'd4, 20'h00055, 1, 3'b000, 0, 20'h00000, 3'b000, 0, 0, 2'd0, 1}); // JS wrap
    vq.push_back('{0, 4'd0, 20'h0,     0, 3'b000, 1, 20'h00000, 3'b000, 0, 0, 2'd0, 1}); // ack in RUN
    vq.push_back('{1, 4'd7, 20'h00003, 1, 3'b001, 0, 20'h00001, 3'b010, 0, 0, 2'd0, 1}); // XSR fwd
    vq.push_back('{1, 4'd2, 20'h00100, 0, 3'b000, 0, 20'h00100, 3'b010, 1, 0, 2'd0, 1}); // JMP 0x100
    vq.push_back('{1, 4'hA, 20'h0,     0, 3'b000, 0, 20'h00010, 3'b010, 1, 1, 2'd1, 0}); // illegal

    rst = 1'b1;
    drive(0, 4'd0, 20'h0, 0, 3'b000, 0);
    step();
    step();
    chk_all("reset", 20'h0, 3'b000, 0, 0, 2'd0, 1);
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].op, vq[i].arg, vq[i].fwe, vq[i].fl, vq[i].ack);
      step();
      chk_all($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_sr, vq[i].e_red,
              vq[i].e_trap, vq[i].e_cause, vq[i].e_rdy);
    end

    // Ops offered during TRAP are ignored; flag writes still land in SR.
    for (int k = 0; k < 5; k++) begin
      drive(1, 4'd2, 20'h0ABCD, (k == 2), 3'b100, 0);
      step();
      chk_all($sformatf("trapwait%0d", k), 20'h00010, (k >= 2) ? 3'b100 : 3'b010,
              0, 1, 2'd1, 0);
    end

    // Handler returns to the instruction after the illegal op.
    drive(0, 4'd0, 20'h0, 0, 3'b000, 1);
    step();
    chk_all("trapret", 20'h00101, 3'b100, 1, 0, 2'd1, 1);

    drive(1, 4'd1, 20'h0, 0, 3'b000, 0);
    step();
    chk_all("postret_nop", 20'h00102, 3'b100, 0, 0, 2'd1, 1);

    // TRAP opcode sets cause 0.
    drive(1, 4'd0, 20'h0, 0, 3'b000, 0);
    step();
    chk_all("trapop", 20'h00010, 3'b100, 1, 1, 2'd0, 0);

    // Reset while trapped returns straight to RUN.
    drive(0, 4'd0, 20'h0, 0, 3'b000, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("rst_in_trap", 20'h0, 3'b000, 0, 0, 2'd0, 1);

    // A stale ack after reset must not restore the abandoned return address.
    drive(0, 4'd0, 20'h0, 0, 3'b000, 1);
    step();
    chk_all("ack_after_rst", 20'h0, 3'b000, 0, 0, 2'd0, 1);

    // Fresh trap after reset records the new return address.
    drive(1, 4'd0, 20'h0, 0, 3'b000, 0);
    step();
    chk_all("trap2", 20'h00010, 3'b000, 1, 1, 2'd0, 0);
    drive(0, 4'd0, 20'h0, 0, 3'b000, 1);
    step();
    chk_all("trap2ret", 20'h00001, 3'b000, 1, 0, 2'd0, 1);
    drive(0, 4'd0, 20'h0, 0, 3'b000, 0);
    step();
    chk_all("trap2idle", 20'h00001, 3'b000, 0, 0, 2'd0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
